// File: rtl/radix4_multiplier_if.sv
// Handshake and operand/result bundle for radix4_multiplier.
// master: controlling FSM or bus wrapper; slave: the multiplier.
interface radix4_multiplier_if;
    logic         op_start;
    logic         op_clear;
    logic [63:0]  multiplicand;
    logic [63:0]  multiplier;
    logic         op_done;
    logic [127:0] result;

    modport master (
        output op_start,
        output op_clear,
        output multiplicand,
        output multiplier,
        input  op_done,
        input  result
    );

    modport slave (
        input  op_start,
        input  op_clear,
        input  multiplicand,
        input  multiplier,
        output op_done,
        output result
    );
endinterface

// File: rtl/radix4_multiplier.sv
// Sequential 64x64 signed radix-4 (modified Booth) multiplier, one digit per clock.
// Optional MULT_BUSY_OUT_EN adds a busy output that is high while iterating.
module radix4_multiplier (
    input  logic clk,
    input  logic reset_n,
`ifdef MULT_BUSY_OUT_EN
    output logic busy,
`endif
    radix4_multiplier_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e       state_q, state_d;
    logic         armed_q, armed_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [127:0] m_q, m_d;
    logic [64:0]  q_q, q_d;
    logic [127:0] acc_q, acc_d;
    logic [127:0] result_q, result_d;
    logic [127:0] term;
    logic [127:0] acc_sum;

    // m_q is pre-shifted by 2i and q_q shifted right, so the digit is always q_q[2:0].
    always_comb begin
        term = '0;
        unique case (q_q[2:0])
            3'b001, 3'b010: term = m_q;
            3'b011:         term = m_q << 1;
            3'b100:         term = -(m_q << 1);
            3'b101, 3'b110: term = -m_q;
            default:        term = '0;
        endcase
    end

    assign acc_sum = acc_q + term;

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        q_d      = q_q;
        acc_d    = acc_q;
        result_d = result_q;

        if (bus.op_clear) begin
            state_d  = StIdle;
            armed_d  = 1'b0;
            cnt_d    = '0;
            m_d      = '0;
            q_d      = '0;
            acc_d    = '0;
            result_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Operands are captured on the start edge; iteration begins one clock later.
                    if (armed_q) begin
                        state_d = StExec;
                        armed_d = 1'b0;
                    end else if (bus.op_start) begin
                        armed_d  = 1'b1;
                        m_d      = {{64{bus.multiplicand[63]}}, bus.multiplicand};
                        q_d      = {bus.multiplier, 1'b0};
                        acc_d    = '0;
                        cnt_d    = '0;
                        result_d = '0;
                    end
                end
                StExec: begin
                    acc_d = acc_sum;
                    m_d   = m_q << 2;
                    q_d   = {{2{q_q[64]}}, q_q[64:2]};
                    cnt_d = 5'(cnt_q + 5'd1);
                    if (cnt_q == 5'd31) begin
                        state_d  = StDone;
                        result_d = acc_sum;
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
            m_q      <= '0;
            q_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            q_q      <= q_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign bus.op_done = (state_q == StDone);
    assign bus.result  = (state_q == StDone) ? result_q : '0;

`ifdef MULT_BUSY_OUT_EN
    assign busy = (state_q == StExec);
`endif

endmodule

// File: tb/tb_radix4_multiplier.sv
// Self-checking bench for radix4_multiplier against a plain 128-bit signed product model.
module tb_radix4_multiplier;

    logic clk;
    logic reset_n;
    logic busy;
    int   checks;
    int   failures;

    radix4_multiplier_if mult_if ();

    radix4_multiplier dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef MULT_BUSY_OUT_EN
        .busy    (busy),
`endif
        .bus     (mult_if.slave)
    );

`ifndef MULT_BUSY_OUT_EN
    assign busy = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] ref_prod(input logic [63:0] m, input logic [63:0] q);
        logic signed [127:0] a;
        logic signed [127:0] b;
        a = {{64{m[63]}}, m};
        b = {{64{q[63]}}, q};
        return a * b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_operand(output logic [63:0] v);
        int unsigned mode;
        mode = $urandom_range(0, 7);
        case (mode)
            0: v = 64'($signed($urandom_range(0, 200)) - 100);
            1: v = 64'h8000_0000_0000_0000;
            2: v = 64'h7FFF_FFFF_FFFF_FFFF;
            3: v = 64'hFFFF_FFFF_FFFF_FFFF;
            default: v = {$urandom, $urandom};
        endcase
    endtask

    // Waits up to 40 edges for op_done; lat counts edges after the start edge.
    task automatic wait_done(input bit scramble, output int lat, output int bcnt);
        logic [63:0] r;
        lat  = 40;
        bcnt = 0;
        if (busy) bcnt++;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (scramble) begin
                rand_operand(r);
                mult_if.multiplicand = r;
                rand_operand(r);
                mult_if.multiplier = r;
            end
            if (busy) bcnt++;
            if (mult_if.op_done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [63:0] m, input logic [63:0] q, input bit scramble,
                          output int lat, output int bcnt);
        mult_if.multiplicand = m;
        mult_if.multiplier   = q;
        mult_if.op_start     = 1'b1;
        tick();
        mult_if.op_start = 1'b0;
        wait_done(scramble, lat, bcnt);
    endtask

    task automatic do_clear();
        mult_if.op_start = 1'b0;
        mult_if.op_clear = 1'b1;
        tick();
        mult_if.op_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n              = 1'b0;
        mult_if.op_start     = 1'b0;
        mult_if.op_clear     = 1'b0;
        mult_if.multiplicand = '0;
        mult_if.multiplier   = '0;
        tick();
        tick();
        checks++;
        if (mult_if.op_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", mult_if.op_done);
        end
        checks++;
        if (mult_if.result !== 128'h0) begin
            failures++;
            $display("FAIL reset_result got=%h exp=0", mult_if.result);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_hold();
        int lat;
        int bcnt;
        mult_if.multiplicand = 64'd5;
        mult_if.multiplier   = -64'sd20;
        mult_if.op_start     = 1'b1;
        tick();
        wait_done(1'b0, lat, bcnt);
        checks++;
        if (lat !== 33) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=33", lat);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mult_if.op_done !== 1'b1 ||
                mult_if.result !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF9C) begin
                failures++;
                $display("FAIL basic_hold done=%b got=%h exp=%h", mult_if.op_done,
                         mult_if.result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF9C);
            end
            tick();
        end
        do_clear();
        checks++;
        if (mult_if.op_done !== 1'b0 || mult_if.result !== 128'h0) begin
            failures++;
            $display("FAIL basic_clear done=%b got=%h exp=0", mult_if.op_done, mult_if.result);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int bcnt;
        mult_if.multiplicand = 64'd5;
        mult_if.multiplier   = -64'sd20;
        mult_if.op_start     = 1'b1;
        tick();
        wait_done(1'b0, lat, bcnt);
        reset_n = 1'b0;
        #1;
        checks++;
        if (mult_if.op_done !== 1'b0 || mult_if.result !== 128'h0) begin
            failures++;
            $display("FAIL reset_in_done done=%b got=%h exp=0", mult_if.op_done, mult_if.result);
        end
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (mult_if.op_done !== 1'b0 || mult_if.result !== 128'h0) begin
            failures++;
            $display("FAIL reset_in_exec done=%b got=%h exp=0", mult_if.op_done, mult_if.result);
        end
        reset_n = 1'b1;
        tick();
        mult_if.multiplicand = 64'd4;
        mult_if.multiplier   = 64'd5;
        mult_if.op_clear     = 1'b1;
        tick();
        checks++;
        if (mult_if.op_done !== 1'b0 || mult_if.result !== 128'h0) begin
            failures++;
            $display("FAIL clear_over_start done=%b got=%h exp=0", mult_if.op_done,
                     mult_if.result);
        end
        mult_if.op_clear = 1'b0;
        tick();
        wait_done(1'b0, lat, bcnt);
        checks++;
        if (lat !== 33 || mult_if.result !== 128'h14) begin
            failures++;
            $display("FAIL restart_after_clear lat=%0d got=%h exp=lat 33 result %h", lat,
                     mult_if.result, 128'h14);
        end
        do_clear();
    endtask

    task automatic test_abort();
        bit seen_done;
        mult_if.multiplicand = 64'd123;
        mult_if.multiplier   = 64'd456;
        mult_if.op_start     = 1'b1;
        tick();
        mult_if.op_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        mult_if.op_clear = 1'b1;
        tick();
        mult_if.op_clear = 1'b0;
        checks++;
        if (mult_if.op_done !== 1'b0 || mult_if.result !== 128'h0) begin
            failures++;
            $display("FAIL abort_outputs done=%b got=%h exp=0", mult_if.op_done, mult_if.result);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mult_if.op_done !== 1'b0 || mult_if.result !== 128'h0) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_spurious_done got=%b exp=0", seen_done);
        end
    endtask

    task automatic test_corners();
        logic [63:0]  ms [4];
        logic [63:0]  qs [4];
        logic [127:0] exp_r [4];
        int lat;
        int bcnt;
        ms[0] = 64'h8000_0000_0000_0000; qs[0] = 64'h8000_0000_0000_0000;
        exp_r[0] = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
        ms[1] = '1; qs[1] = '1; exp_r[1] = 128'h1;
        ms[2] = '0; qs[2] = 64'h8765_4321_DEAD_BEEF; exp_r[2] = 128'h0;
        ms[3] = 64'h7FFF_FFFF_FFFF_FFFF; qs[3] = 64'h8000_0000_0000_0000;
        exp_r[3] = 128'hC000_0000_0000_0000_8000_0000_0000_0000;
        for (int i = 0; i < 4; i++) begin
            run_op(ms[i], qs[i], 1'b0, lat, bcnt);
            checks++;
            if (lat !== 33 || mult_if.result !== exp_r[i]) begin
                failures++;
                $display("FAIL corner_%0d lat=%0d got=%h exp=%h", i, lat, mult_if.result,
                         exp_r[i]);
            end
            do_clear();
        end
    endtask

    task automatic test_operand_change();
        logic [63:0] m;
        logic [63:0] q;
        int lat;
        int bcnt;
        for (int i = 0; i < 5; i++) begin
            m = {$urandom, $urandom};
            q = {$urandom, $urandom};
            run_op(m, q, 1'b1, lat, bcnt);
            checks++;
            if (lat !== 33 || mult_if.result !== ref_prod(m, q)) begin
                failures++;
                $display("FAIL operand_change lat=%0d got=%h exp=%h", lat, mult_if.result,
                         ref_prod(m, q));
            end
            do_clear();
        end
    endtask

    task automatic test_random();
        logic [63:0] m;
        logic [63:0] q;
        int lat;
        int bcnt;
        for (int i = 0; i < 1000; i++) begin
            rand_operand(m);
            rand_operand(q);
            run_op(m, q, 1'b0, lat, bcnt);
            checks++;
            if (lat !== 33 || mult_if.result !== ref_prod(m, q)) begin
                failures++;
                $display("FAIL random_%0d m=%h q=%h lat=%0d got=%h exp=%h", i, m, q, lat,
                         mult_if.result, ref_prod(m, q));
            end
`ifdef MULT_BUSY_OUT_EN
            checks++;
            if (bcnt !== 32) begin
                failures++;
                $display("FAIL busy_cycles_%0d got=%0d exp=32", i, bcnt);
            end
`endif
            do_clear();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_hold();
        test_reset_mid_run();
        test_abort();
        test_corners();
        test_operand_change();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
